fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It generates sequential PCs, drives a single-outstanding-request handshake to instruction memory, and buffers returned words in a small FIFO. It presents {PC, instruction, valid_PC} to IF/ID and honours stall and branch/jump redirect from the hazard and EX logic.

Parameters:
PC_W, 8, PC/address width; byte addressed.
INSTR_W, 32, instruction width.
RESET_PC, 8'h00, first fetch address after reset.
BUF_DEPTH, 2, fetch FIFO entries; power of two, ≥2.

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  synchronous active-low reset
stall  in  1  IF/ID holding this cycle; no pop
redirect  in  1  taken branch/jump; flush and refetch
redirect_pc  in  PC_W  redirect target
imem_req  out  1  memory request valid
imem_addr  out  PC_W  request address; stable while imem_req && !imem_ack
imem_ack  in  1  request accepted and imem_rdata valid in this same cycle
imem_rdata  in  INSTR_W  instruction word
PC  out  PC_W  PC of FIFO head; fetch_pc when empty
instruction  out  INSTR_W  FIFO head word; 0 when empty
valid_PC  out  1  FIFO non-empty

Behaviour:
- Reset (rst_n=0 at posedge): fetch_pc=RESET_PC, req_addr=RESET_PC, FIFO empty (count=0, pointers 0), state IDLE. Outputs next cycle: imem_req=0, valid_PC=0, instruction=0, PC=RESET_PC. A reset mid-request abandons it; an ack arriving during reset is ignored.
- State register: IDLE (nothing outstanding), REQ (req_addr outstanding, data wanted), DROP (req_addr outstanding, data discarded). imem_req = (state != IDLE). imem_addr = req_addr.
- space = (count_next + 0) < BUF_DEPTH, where count_next = count after this cycle's push/pop.
- IDLE: if space, then req_addr <= fetch_pc and go to REQ.
- REQ and imem_ack: push {req_addr, imem_rdata}. fetch_pc <= req_addr+4. If space remains after the push, req_addr <= req_addr+4 and stay in REQ (back-to-back, one word per cycle with zero-wait memory). Otherwise go to IDLE.
- REQ without ack: hold req_addr.
- DROP: hold req_addr until imem_ack, discard the data, then req_addr <= fetch_pc and go to REQ.
- Pop: at posedge when valid_PC && !stall && !redirect. Push and pop in the same cycle are legal, including when the FIFO is full or holds one entry.
- Redirect has highest priority after reset, regardless of stall.
  - FIFO cleared.
  - fetch_pc <= redirect_pc.
  - IDLE → REQ with req_addr = redirect_pc.
  - REQ with ack → data dropped; REQ with req_addr = redirect_pc.
  - REQ without ack → DROP (req_addr unchanged).
  - DROP → stays DROP, or REQ at redirect_pc if ack arrives the same cycle.
- Outputs are combinational from FIFO head; no bypass from imem_rdata. Fetch latency: ack cycle t → valid_PC at t+1.
- PC arithmetic is modulo 2^PC_W: 8'hFC+4 wraps to 8'h00. No alignment check; the low two bits pass through.
- stall blocks only the pop. Fetching continues until the FIFO is full, then imem_req deasserts (IDLE).
- Never more than one outstanding request. The FIFO never overflows: a push while full without a pop is impossible by construction (assertion).

Decomposition:
- Shared package cpu_pkg: PC_W, INSTR_W, RESET_PC, NOP_INSTR (32'h0), fetch state enum {IDLE, REQ, DROP}.
- One sub-module, fetch_fifo: a synchronous FIFO of {PC, instruction} with push/pop/clear, count, empty/full, and a combinational head. The control FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset then zero-wait memory (ack=imem_req), stall=0 → imem_addr 00,04,08 on consecutive cycles; valid_PC from cycle 2; PC sequence 00,04,08 with matching rdata.
- Memory with 3-cycle ack latency → imem_addr held at 04 for 3 cycles; valid_PC pulses once per 3 cycles; no duplicate or missing PC.
- stall=1 for 5 cycles with zero-wait memory → FIFO fills with 2 entries, imem_req=0, PC/instruction frozen at head. On release the entries pop in order, then fetch resumes at the next PC.
- redirect=1, redirect_pc=8'h40 while a request to 8'h10 is outstanding (ack 2 cycles later) → FIFO cleared, valid_PC=0, state DROP; 8'h10 data discarded on ack; next imem_addr=8'h40; first valid PC=8'h40.
- redirect with ack in the same cycle, and redirect while stall=1 → data discarded, FIFO cleared, next request at the target; redirect overrides stall.
- fetch_pc=8'hF8 sequential → PCs F8, FC, 00, 04. rst_n=0 asserted mid-request with ack pending → next cycle imem_req=0, valid_PC=0, PC=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU constants and the fetch-stage state type.
//                PC_W      - PC / instruction-memory address width (bytes)
//                INSTR_W   - instruction word width
//                RESET_PC  - first fetch address after reset
//                NOP_INSTR - word presented to IF/ID when nothing is valid
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int              PC_W      = 8;
    localparam int              INSTR_W   = 32;
    localparam logic [PC_W-1:0] RESET_PC  = 8'h00;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;

    // IDLE : nothing outstanding
    // REQ  : request outstanding, returned word is wanted
    // DROP : request outstanding, returned word is discarded (stale after redirect)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO of {PC, instruction} pairs for the fetch
//                stage. Push and pop may occur in the same cycle, including
//                when full. Clear empties the FIFO in one cycle.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                i_clear             - flush all entries
//                i_push, i_push_pc,
//                i_push_instr        - write one entry
//                i_pop               - consume the head entry
//                o_head_pc,
//                o_head_instr        - head entry (combinational)
//                o_count, o_empty    - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH   = 2,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic [PC_W-1:0]         i_push_pc,
    input  logic [INSTR_W-1:0]      i_push_instr,
    input  logic                    i_pop,
    output logic [PC_W-1:0]         o_head_pc,
    output logic [INSTR_W-1:0]      o_head_instr,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full;
    logic               w_wr_en;
    logic               w_rd_en;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_rd_en = i_pop && !o_empty;
    // A write while full is only accepted when the head leaves in the same cycle.
    assign w_wr_en = i_push && (!w_full || w_rd_en);

    assign o_head_pc    = r_pc_mem[r_rd_ptr];
    assign o_head_instr = r_instr_mem[r_rd_ptr];
    assign o_count      = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_pc_mem[r_wr_ptr]    <= i_push_pc;
                r_instr_mem[r_wr_ptr] <= i_push_instr;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The fetch controller only requests when space is guaranteed.
    always_ff @(posedge clk) begin
        if (rst_n && !i_clear) begin
            assert (!(i_push && w_full && !w_rd_en));
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage feeding the IF/ID register. Issues
//                sequential PCs to instruction memory with a single
//                outstanding request, buffers returned words in a small
//                FIFO and honours stall and branch/jump redirect.
//  Ports       : clk, rst_n            - clock, synchronous active-low reset
//                stall                 - IF/ID holding, no pop this cycle
//                redirect, redirect_pc - flush and refetch from target
//                imem_req, imem_addr   - memory request (addr stable until ack)
//                imem_ack, imem_rdata  - same-cycle accept + data
//                PC, instruction,
//                valid_PC              - FIFO head presented to IF/ID
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              PC_W      = cpu_pkg::PC_W,
    parameter int              INSTR_W   = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] instruction,
    output logic               valid_PC
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e       r_state;
    logic [PC_W-1:0]    r_fetch_pc;
    logic [PC_W-1:0]    r_req_addr;

    logic [PC_W-1:0]    w_next_addr;
    logic               w_push;
    logic               w_pop;
    logic               w_space;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [PC_W-1:0]    w_head_pc;
    logic [INSTR_W-1:0] w_head_instr;

    // Modulo-2^PC_W increment; low address bits pass through untouched.
    assign w_next_addr = r_req_addr + PC_W'(4);

    // A redirect flushes the FIFO, so neither push nor pop may happen with it.
    assign w_pop  = !w_empty && !stall && !redirect;
    assign w_push = (r_state == REQ) && imem_ack && !redirect;

    always_comb begin
        w_count_next = w_count;
        if (redirect) begin
            w_count_next = '0;
        end else begin
            w_count_next = w_count + {{(CNT_W-1){1'b0}}, w_push}
                                   - {{(CNT_W-1){1'b0}}, w_pop};
        end
    end

    // Room for one more word once this cycle's push/pop have settled.
    assign w_space = (w_count_next < CNT_W'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            // An unacked request cannot be withdrawn; its data must be discarded.
            if (r_state == IDLE || imem_ack) begin
                r_state    <= REQ;
                r_req_addr <= redirect_pc;
            end else begin
                r_state    <= DROP;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_space) begin
                        r_state    <= REQ;
                        r_req_addr <= r_fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        r_fetch_pc <= w_next_addr;
                        if (w_space) begin
                            r_req_addr <= w_next_addr;
                        end else begin
                            r_state    <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        r_state    <= REQ;
                        r_req_addr <= r_fetch_pc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (redirect),
        .i_push       (w_push),
        .i_push_pc    (r_req_addr),
        .i_push_instr (imem_rdata),
        .i_pop        (w_pop),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_count      (w_count),
        .o_empty      (w_empty)
    );

    assign imem_req    = (r_state != IDLE);
    assign imem_addr   = r_req_addr;
    assign valid_PC    = !w_empty;
    assign PC          = w_empty ? r_fetch_pc : w_head_pc;
    assign instruction = w_empty ? INSTR_W'(NOP_INSTR) : w_head_instr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A memory model answers
//                requests after a programmable latency; a reference model
//                tracks the PC stream IF/ID must observe (sequential from the
//                last reset/redirect, advancing on each consumed word).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [7:0]  PC;
    logic [31:0] instruction;
    logic        valid_PC;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_W      (8),
        .INSTR_W   (32),
        .RESET_PC  (8'h00),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .instruction (instruction),
        .valid_PC    (valid_PC)
    );

    int         n_total = 0;
    int         n_bad   = 0;
    int         n_pops  = 0;
    logic [7:0] exp_pc;
    int         lat;
    int         wait_left;
    bit         rand_lat;
    logic       prev_req;
    logic       prev_ack;
    logic       prev_rn;
    logic [7:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        logic [7:0] b;
        b = a + 8'hC3;
        return {a, ~a, a ^ 8'h5A, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: checks current outputs against the model, drives
    // the inputs for the next posedge, advances the model, then steps one cycle.
    task automatic cycle(input logic s, input logic r, input logic [7:0] rpc, input logic rn);
        logic ack;
        check("pc", 32'(PC), 32'(exp_pc));
        if (valid_PC) check("instr", instruction, mem_word(exp_pc));
        else          check("instr_empty", instruction, 32'h0);
        if (prev_rn && prev_req && !prev_ack) begin
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", 32'(imem_addr), 32'(prev_addr));
        end
        ack = 1'b0;
        if (imem_req) begin
            if (wait_left == 0) ack = 1'b1;
            else wait_left--;
        end
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        rst_n       = rn;
        imem_ack    = ack;
        imem_rdata  = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        prev_req    = imem_req;
        prev_ack    = ack;
        prev_addr   = imem_addr;
        prev_rn     = rn;
        if (!rn) begin
            exp_pc = 8'h00;
        end else if (r) begin
            exp_pc = rpc;
        end else if (valid_PC && !s) begin
            exp_pc = exp_pc + 8'd4;
            n_pops++;
        end
        @(posedge clk);
        if (!rn || ack) wait_left = rand_lat ? int'($urandom_range(0, 3)) : lat;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        exp_pc = 8'h00; lat = 0; wait_left = 0; rand_lat = 1'b0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_rn = 1'b0; prev_addr = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_valid", 32'(valid_PC), 32'd0);
        check("rst_pc",    32'(PC), 32'h00);
        check("rst_instr", instruction, 32'h0);

        // Zero-wait memory: back-to-back requests 00, 04, 08
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("zw_req0",   32'(imem_req), 32'd1);
        check("zw_addr0",  32'(imem_addr), 32'h00);
        check("zw_valid0", 32'(valid_PC), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("zw_addr1",  32'(imem_addr), 32'h04);
        check("zw_valid1", 32'(valid_PC), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("zw_addr2",  32'(imem_addr), 32'h08);

        // Three-cycle memory latency
        lat = 2; n_pops = 0;
        repeat (21) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("slow_rate", 32'(n_pops >= 5 && n_pops <= 8), 32'd1);

        // Stall fills the FIFO and stops requesting
        lat = 0; wait_left = 0;
        repeat (5) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("stall_req",   32'(imem_req), 32'd0);
        check("stall_valid", 32'(valid_PC), 32'd1);
        n_pops = 0;
        repeat (6) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("stall_resume", 32'(n_pops >= 3), 32'd1);

        // Redirect with an outstanding, unacked request -> DROP
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        lat = 2; wait_left = 2;
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("d_req",  32'(imem_req), 32'd1);
        check("d_addr", 32'(imem_addr), 32'h00);
        cycle(1'b0, 1'b1, 8'h40, 1'b1);
        check("d_valid",    32'(valid_PC), 32'd0);
        check("d_req_drop", 32'(imem_req), 32'd1);
        check("d_addr_drop", 32'(imem_addr), 32'h00);
        for (int i = 0; i < 10 && imem_addr == 8'h00; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("d_target", 32'(imem_addr), 32'h40);
        n_pops = 0;
        repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("d_first", 32'(n_pops >= 1), 32'd1);

        // Redirect in the same cycle as an ack
        lat = 0; wait_left = 0;
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("e_req_before", 32'(imem_req), 32'd1);
        cycle(1'b0, 1'b1, 8'h80, 1'b1);
        check("e_ack_req",   32'(imem_req), 32'd1);
        check("e_ack_addr",  32'(imem_addr), 32'h80);
        check("e_ack_valid", 32'(valid_PC), 32'd0);

        // Redirect while stalled with a full FIFO
        repeat (5) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("e_full_req",   32'(imem_req), 32'd0);
        check("e_full_valid", 32'(valid_PC), 32'd1);
        cycle(1'b1, 1'b1, 8'hA0, 1'b1);
        check("e_stall_req",   32'(imem_req), 32'd1);
        check("e_stall_addr",  32'(imem_addr), 32'hA0);
        check("e_stall_valid", 32'(valid_PC), 32'd0);
        n_pops = 0;
        repeat (6) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("e_resume", 32'(n_pops >= 3), 32'd1);

        // Address wrap F8, FC, 00, 04
        cycle(1'b0, 1'b1, 8'hF8, 1'b1);
        n_pops = 0;
        repeat (8) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("f_wrap_pops", 32'(n_pops >= 4), 32'd1);

        // Reset mid-request with an ack arriving during reset
        lat = 3; wait_left = 3;
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("f_pending", 32'(imem_req), 32'd1);
        wait_left = 0;
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("r_req",   32'(imem_req), 32'd0);
        check("r_valid", 32'(valid_PC), 32'd0);
        check("r_pc",    32'(PC), 32'h00);
        check("r_instr", instruction, 32'h0);

        // Randomized traffic
        rand_lat = 1'b1;
        n_pops = 0;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 5,
                  8'($urandom),
                  $urandom_range(0, 199) != 0);
        end
        check("rand_progress", 32'(n_pops > 50), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
